// File: rtl/sd_pkg.sv
// Shared types and constants for the SD single-block read engine.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_DATA,
        ST_CRC,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] START_TOKEN    = 8'hFE;
    localparam logic [7:0] IDLE_BYTE      = 8'hFF;
    localparam logic [8:0] LAST_BYTE_IDX  = 9'd511;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd1;
    localparam logic [1:0] ERR_DATA_TOKEN = 2'd2;

    // Card data-error tokens have the top three bits clear.
    function automatic logic is_error_token(input logic [7:0] b);
        return (b[7:5] == 3'b000);
    endfunction

endpackage

// File: rtl/sd_sector_fill.sv
// Reads one 512-byte SD data block over a byte-wide SPI engine: polls for the
// start token, streams the payload into the sector buffer, then captures CRC16.
module sd_sector_fill
    import sd_pkg::*;
#(
    parameter logic [15:0] TOKEN_TIMEOUT = 16'd65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] crc,
    output logic        spi_start,
    output logic [7:0]  spi_tx,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx,
    output logic [8:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_en
);

    state_t      state_q, state_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [8:0]  byte_cnt_q, byte_cnt_d;
    logic        crc_hi_q, crc_hi_d;
    logic [15:0] crc_q, crc_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        spi_start_q, spi_start_d;
    logic        wr_en_q, wr_en_d;
    logic [8:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            poll_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            crc_hi_q    <= 1'b0;
            crc_q       <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            spi_start_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            poll_cnt_q  <= poll_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            crc_hi_q    <= crc_hi_d;
            crc_q       <= crc_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            spi_start_q <= spi_start_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // A new transfer is launched on entry to each transfer state and after every
    // spi_done that keeps the state, so exactly one byte is ever in flight.
    always_comb begin
        state_d     = state_q;
        poll_cnt_d  = poll_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        crc_hi_d    = crc_hi_q;
        crc_d       = crc_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        spi_start_d = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_POLL;
                    err_d       = 1'b0;
                    err_code_d  = ERR_NONE;
                    poll_cnt_d  = '0;
                    byte_cnt_d  = '0;
                    crc_hi_d    = 1'b0;
                    spi_start_d = 1'b1;
                end
            end
            ST_POLL: begin
                if (spi_done) begin
                    if (spi_rx == START_TOKEN) begin
                        state_d     = ST_DATA;
                        spi_start_d = 1'b1;
                    end else if (is_error_token(spi_rx)) begin
                        state_d    = ST_ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_DATA_TOKEN;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                        if (poll_cnt_q + 16'd1 == TOKEN_TIMEOUT) begin
                            state_d    = ST_ERR;
                            err_d      = 1'b1;
                            err_code_d = ERR_TIMEOUT;
                        end else begin
                            spi_start_d = 1'b1;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (spi_done) begin
                    wr_en_d     = 1'b1;
                    wr_data_d   = spi_rx;
                    wr_addr_d   = byte_cnt_q;
                    byte_cnt_d  = byte_cnt_q + 9'd1;
                    spi_start_d = 1'b1;
                    if (byte_cnt_q == LAST_BYTE_IDX) begin
                        state_d = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                if (spi_done) begin
                    if (!crc_hi_q) begin
                        crc_d[15:8] = spi_rx;
                        crc_hi_d    = 1'b1;
                        spi_start_d = 1'b1;
                    end else begin
                        crc_d[7:0] = spi_rx;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q == ST_POLL) || (state_q == ST_DATA) || (state_q == ST_CRC);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign crc       = crc_q;
    assign spi_start = spi_start_q;
    assign spi_tx    = IDLE_BYTE;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_sd_sector_fill.sv
// Directed scoreboard bench for sd_sector_fill with a behavioural SPI byte responder.
module tb_sd_sector_fill;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [15:0] crc;
    logic        spi_start;
    logic [7:0]  spi_tx;
    logic        spi_done = 1'b0;
    logic [7:0]  spi_rx = 8'h00;
    logic [8:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;

    logic [16:0] exp_wr[$];
    logic [7:0]  rx_src[$];

    sd_sector_fill #(.TOKEN_TIMEOUT(16'd4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .crc(crc),
        .spi_start(spi_start), .spi_tx(spi_tx), .spi_done(spi_done), .spi_rx(spi_rx),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit seen = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_err(input string tag, input int max_cyc);
        bit seen = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (err === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_writes(input string tag, input int target, input int max_cyc);
        bit seen = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (wr_cnt >= target) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    // Queue a full block on the card side and its 512 expected buffer writes.
    task automatic push_block(input int n_ff, input logic [7:0] pat, input logic [15:0] c);
        logic [7:0] d;
        logic [8:0] a;
        for (int i = 0; i < n_ff; i++) rx_src.push_back(8'hFF);
        rx_src.push_back(8'hFE);
        for (int i = 0; i < 512; i++) begin
            a = i[8:0];
            d = a[7:0] ^ pat;
            rx_src.push_back(d);
            exp_wr.push_back({a, d});
        end
        rx_src.push_back(c[15:8]);
        rx_src.push_back(c[7:0]);
    endtask

    initial begin
        int base_wr, base_x, base_d;
        logic [7:0] d;
        logic [8:0] a;

        fork
            begin : responder
                forever begin
                    @(posedge clk);
                    if (spi_start === 1'b1) begin
                        xfer_cnt++;
                        repeat (2) @(posedge clk);
                        #1;
                        if (rx_src.size() != 0) spi_rx = rx_src.pop_front();
                        else spi_rx = 8'hFF;
                        spi_done = 1'b1;
                        @(posedge clk);
                        #1 spi_done = 1'b0;
                    end
                end
            end
            begin : monitor
                logic [16:0] e;
                forever begin
                    @(negedge clk);
                    if (done === 1'b1) done_cnt++;
                    if (wr_en === 1'b1) begin
                        wr_cnt++;
                        n_tests++;
                        assert (exp_wr.size() != 0) else begin
                            n_fail++;
                            $error("FAIL wr_unexpected observed addr=0x%0h data=0x%0h expected no write",
                                   wr_addr, wr_data);
                        end
                        if (exp_wr.size() != 0) begin
                            e = exp_wr.pop_front();
                            chk("wr_addr_data", {15'd0, wr_addr, wr_data}, {15'd0, e});
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
        chk("rst_crc", {16'd0, crc}, 32'd0);
        chk("rst_spi_start", {31'd0, spi_start}, 32'd0);
        chk("rst_spi_tx", {24'd0, spi_tx}, 32'hFF);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {23'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good block: token after three idle bytes, data = address low byte
        base_wr = wr_cnt; base_x = xfer_cnt; base_d = done_cnt;
        push_block(3, 8'h00, 16'hABCD);
        pulse_start();
        chk("blk1_busy", {31'd0, busy}, 32'd1);
        chk("blk1_spi_tx", {24'd0, spi_tx}, 32'hFF);
        wait_done("blk1_done_seen", 4000);
        chk("blk1_crc", {16'd0, crc}, 32'hABCD);
        chk("blk1_busy_low", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("blk1_writes", wr_cnt - base_wr, 32'd512);
        chk("blk1_xfers", xfer_cnt - base_x, 32'd518);
        chk("blk1_done_pulses", done_cnt - base_d, 32'd1);
        chk("blk1_exp_left", exp_wr.size(), 32'd0);
        chk("blk1_err", {31'd0, err}, 32'd0);

        // Token timeout: card only ever returns 0xFF
        base_wr = wr_cnt; base_x = xfer_cnt;
        pulse_start();
        wait_err("to_err_seen", 200);
        chk("to_err_code", {30'd0, err_code}, 32'd1);
        chk("to_busy", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge clk);
        chk("to_xfers", xfer_cnt - base_x, 32'd4);
        chk("to_writes", wr_cnt - base_wr, 32'd0);
        chk("to_err_held", {31'd0, err}, 32'd1);

        // Clean block after an error: err clears on accept
        base_wr = wr_cnt; base_d = done_cnt;
        push_block(0, 8'hA5, 16'h1234);
        pulse_start();
        chk("rec_err_clr", {31'd0, err}, 32'd0);
        chk("rec_code_clr", {30'd0, err_code}, 32'd0);
        wait_done("rec_done_seen", 4000);
        chk("rec_crc", {16'd0, crc}, 32'h1234);
        repeat (3) @(negedge clk);
        chk("rec_writes", wr_cnt - base_wr, 32'd512);
        chk("rec_done_pulses", done_cnt - base_d, 32'd1);

        // Data-error token
        base_wr = wr_cnt;
        rx_src.push_back(8'hFF);
        rx_src.push_back(8'h05);
        pulse_start();
        wait_err("dtok_err_seen", 200);
        chk("dtok_err_code", {30'd0, err_code}, 32'd2);
        chk("dtok_busy", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge clk);
        chk("dtok_writes", wr_cnt - base_wr, 32'd0);

        // start pulsed mid-DATA must be ignored
        base_wr = wr_cnt; base_d = done_cnt;
        push_block(1, 8'h3C, 16'hBEEF);
        pulse_start();
        wait_writes("mid_reach50", base_wr + 50, 2000);
        pulse_start();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        wait_done("mid_done_seen", 4000);
        chk("mid_crc", {16'd0, crc}, 32'hBEEF);
        repeat (10) @(negedge clk);
        chk("mid_writes", wr_cnt - base_wr, 32'd512);
        chk("mid_done_pulses", done_cnt - base_d, 32'd1);
        chk("mid_busy_idle", {31'd0, busy}, 32'd0);

        // Reset after 100 data bytes, then a normal block
        base_wr = wr_cnt; base_d = done_cnt;
        rx_src.push_back(8'hFE);
        for (int i = 0; i < 100; i++) begin
            a = i[8:0];
            d = a[7:0] ^ 8'h77;
            rx_src.push_back(d);
            exp_wr.push_back({a, d});
        end
        pulse_start();
        wait_writes("rst_reach100", base_wr + 100, 2000);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("mrst_spi_start", {31'd0, spi_start}, 32'd0);
        chk("mrst_crc", {16'd0, crc}, 32'd0);
        chk("mrst_wr_addr", {23'd0, wr_addr}, 32'd0);
        base_x = xfer_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("mrst_writes", wr_cnt - base_wr, 32'd100);
        chk("mrst_xfers", xfer_cnt - base_x, 32'd0);
        chk("mrst_done", done_cnt - base_d, 32'd0);
        chk("mrst_err", {31'd0, err}, 32'd0);
        chk("mrst_exp_left", exp_wr.size(), 32'd0);
        rx_src.delete();

        base_wr = wr_cnt; base_d = done_cnt;
        push_block(2, 8'h0F, 16'h5AA5);
        pulse_start();
        wait_done("post_done_seen", 4000);
        chk("post_crc", {16'd0, crc}, 32'h5AA5);
        repeat (3) @(negedge clk);
        chk("post_writes", wr_cnt - base_wr, 32'd512);
        chk("post_done_pulses", done_cnt - base_d, 32'd1);
        chk("post_exp_left", exp_wr.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_sector_fill.md
SD_SECTOR_FILL -- requirements
Module: sd_sector_fill

Interface
REQ-001 Parameter: TOKEN_TIMEOUT, 16'd65535, maximum 0xFF poll bytes before giving up on the start token.
REQ-002 Port: clk  input  1  sole clock, all logic on rising edge.
REQ-003 Port: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 Port: start  input  1  one-cycle request to read one 512-byte data block after a read command has been issued.
REQ-005 Port: busy  output  1  high from accepted start until done/err.
REQ-006 Port: done  output  1  one-cycle pulse, block fully received.
REQ-007 Port: err  output  1  level, block aborted; held until next accepted start.
REQ-008 Port: err_code  output  2  0 none, 1 token timeout, 2 data-error token.
REQ-009 Port: crc  output  16  received CRC16, first byte in [15:8].
REQ-010 Port: spi_start  output  1  one-cycle pulse launching one SPI byte transfer.
REQ-011 Port: spi_tx  output  8  byte to send; constant 8'hFF.
REQ-012 Port: spi_done  input  1  one-cycle pulse, transfer complete, spi_rx valid.
REQ-013 Port: spi_rx  input  8  received byte.
REQ-014 Port: wr_addr  output  9  sector-buffer write address.
REQ-015 Port: wr_data  output  8  sector-buffer write data.
REQ-016 Port: wr_en  output  1  sector-buffer write strobe, one cycle per byte.

Function
REQ-017 States SHALL be IDLE, POLL, DATA, CRC, DONE, ERR.
REQ-018 IDLE: start=1 -> POLL, clear err/err_code/poll counter/byte counter; start ignored in every other state.
REQ-019 Each of POLL/DATA/CRC SHALL pulse spi_start one cycle on entry and one cycle after each spi_done that keeps the state; exactly one transfer outstanding.
REQ-020 POLL on spi_done: rx=8'hFE -> DATA; rx=8'hFF -> increment counter, ERR code 1 when counter reaches TOKEN_TIMEOUT; rx[7:5]=3'b000 -> ERR code 2; any other value treated as 8'hFF.
REQ-021 DATA on spi_done: cycle after, wr_en=1, wr_data=spi_rx, wr_addr=byte count (0..511, incrementing, 9-bit); after byte 511 -> CRC, no wrap write.
REQ-022 CRC: two transfers, first into crc[15:8], second into crc[7:0]; then DONE.
REQ-023 DONE: done=1 one cycle, -> IDLE; ERR: err=1 held, -> IDLE same cycle (err stays until next start).
REQ-024 busy=1 in POLL, DATA, CRC; 0 in IDLE, DONE, ERR.
REQ-025 spi_done outside POLL/DATA/CRC SHALL be ignored; no wr_en outside DATA writes.
REQ-026 Latency: exactly 512 wr_en pulses per successful block; done no earlier than one cycle after the final CRC spi_done.

Reset
REQ-027 rst_n=0 SHALL force IDLE, all outputs 0 (spi_tx 8'hFF), counters 0, crc 0, on the next rising edge.
REQ-028 Reset mid-block SHALL abort with no further wr_en, spi_start, done or err.

Structure
REQ-029 Package sd_pkg SHALL hold state enum, START_TOKEN 8'hFE, IDLE_BYTE 8'hFF, error-code constants.
REQ-030 No sub-module; wr_* ports connect directly to the sector buffer write port.

Verification
REQ-031 Token after 3 0xFF bytes, data 0..511 = addr[7:0], CRC 0xAB,0xCD -> 512 writes addr=data low byte, crc=16'hABCD, one done pulse.
REQ-032 TOKEN_TIMEOUT=4, spi_rx always 0xFF -> 4 transfers, err=1, err_code=1, no wr_en.
REQ-033 Token 8'h05 -> err_code=2, zero writes, busy falls.
REQ-034 start pulsed during DATA -> ignored, byte count unchanged.
REQ-035 rst_n low after 100 data bytes -> outputs 0 next edge, no further writes; new start completes normally.
REQ-036 err then new start with clean block -> err clears on accept, done pulses.
